// File: rtl/gamepad_pmod_multi.sv
// Gamepad Pmod receiver for 1..4 controllers: synchronised shift/latch capture, per-pad decode,
// press/release events and a latch watchdog. Define GAMEPAD_PMOD_REPEAT_EN to build auto-repeat.
module gamepad_pmod_multi #(
    parameter int NUM_PADS       = 2,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int REPEAT_DELAY   = 15,
    parameter int REPEAT_PERIOD  = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     pmod_data_i,
    input  logic                     pmod_clk_i,
    input  logic                     pmod_latch_i,
    output logic [12*NUM_PADS-1:0]   buttons_o,
    output logic [12*NUM_PADS-1:0]   press_o,
    output logic [12*NUM_PADS-1:0]   release_o,
    output logic [NUM_PADS-1:0]      is_present_o,
    output logic                     frame_strobe_o,
    output logic                     timeout_o
);

    localparam int TOTAL = 12 * NUM_PADS;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       syncA_q, syncB_q;
    logic             clkPrev_q, latchPrev_q;
    logic             clkEdge, latchEdge, dataS;
    logic [TOTAL-1:0] shift_q, data_q, oldLevels_q;
    logic [TOTAL-1:0] levels, repeatMask;
    logic [NUM_PADS-1:0] present;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             wdFire, commit_q, timeout_q;
    logic [TOTAL-1:0] press_q, release_q;
    logic             strobe_q;

    // Synchroniser bits are {latch, clk, data}; data shares the clk path latency.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            syncA_q     <= '0;
            syncB_q     <= '0;
            clkPrev_q   <= 1'b0;
            latchPrev_q <= 1'b0;
        end else begin
            syncA_q     <= {pmod_latch_i, pmod_clk_i, pmod_data_i};
            syncB_q     <= syncA_q;
            clkPrev_q   <= syncB_q[1];
            latchPrev_q <= syncB_q[2];
        end
    end

    assign clkEdge   = syncB_q[1] & ~clkPrev_q;
    assign latchEdge = syncB_q[2] & ~latchPrev_q;
    assign dataS     = syncB_q[0];

    always_comb begin
        wd_d   = wd_q;
        wdFire = 1'b0;
        if (latchEdge) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d   = wd_q + WD_W'(1);
            wdFire = (wd_q == WD_LAST);
        end
    end

    // A latch edge takes priority over a coincident clock edge, so that bit is dropped.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shift_q   <= '1;
            data_q    <= '1;
            wd_q      <= '0;
            commit_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            wd_q     <= wd_d;
            commit_q <= latchEdge | wdFire;
            if (latchEdge) begin
                data_q    <= shift_q;
                shift_q   <= '1;
                timeout_q <= 1'b0;
            end else begin
                if (clkEdge) begin
                    shift_q <= {shift_q[TOTAL-2:0], dataS};
                end
                if (wdFire) begin
                    data_q    <= '1;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        levels  = '0;
        present = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (data_q[12*p +: 12] != 12'hFFF) begin
                present[p]         = 1'b1;
                levels[12*p +: 12] = data_q[12*p +: 12];
            end
        end
    end

`ifdef GAMEPAD_PMOD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [NUM_PADS-1:0][RPT_W-1:0] rptCnt_q, rptCnt_d;
    logic [NUM_PADS-1:0]            rptArmed_q, rptArmed_d;
    logic [RPT_W-1:0]               cntNext;

    // Counter restarts on any change; first target is the delay, then the period once armed.
    always_comb begin
        rptCnt_d   = rptCnt_q;
        rptArmed_d = rptArmed_q;
        repeatMask = '0;
        cntNext    = '0;
        if (commit_q) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                if (levels[12*p +: 12] != oldLevels_q[12*p +: 12] || levels[12*p +: 12] == 12'h000) begin
                    rptCnt_d[p]   = '0;
                    rptArmed_d[p] = 1'b0;
                end else begin
                    cntNext = rptCnt_q[p] + RPT_W'(1);
                    if (cntNext == (rptArmed_q[p] ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY))) begin
                        repeatMask[12*p +: 12] = levels[12*p +: 12];
                        rptCnt_d[p]            = '0;
                        rptArmed_d[p]          = 1'b1;
                    end else begin
                        rptCnt_d[p] = cntNext;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptCnt_q   <= '0;
            rptArmed_q <= '0;
        end else begin
            rptCnt_q   <= rptCnt_d;
            rptArmed_q <= rptArmed_d;
        end
    end
`else
    assign repeatMask = '0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            oldLevels_q <= '0;
            press_q     <= '0;
            release_q   <= '0;
            strobe_q    <= 1'b0;
        end else if (commit_q) begin
            oldLevels_q <= levels;
            press_q     <= (levels & ~oldLevels_q) | repeatMask;
            release_q   <= ~levels & oldLevels_q;
            strobe_q    <= 1'b1;
        end else begin
            press_q   <= '0;
            release_q <= '0;
            strobe_q  <= 1'b0;
        end
    end

    assign buttons_o      = levels;
    assign is_present_o   = present;
    assign press_o        = press_q;
    assign release_o      = release_q;
    assign frame_strobe_o = strobe_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_gamepad_pmod_multi.sv
// Directed bench for gamepad_pmod_multi: frame table plus collision, auto-repeat, watchdog and reset sequences.
module tb_gamepad_pmod_multi;

   localparam int NP  = 2;
   localparam int TOT = 12 * NP;
   localparam int TMO = 200;

   logic clk = 1'b0;
   logic reset, pmodData, pmodClk, pmodLatch;
   logic [TOT-1:0] buttons, press, rel;
   logic [NP-1:0] isPresent;
   logic frameStrobe, timeoutSig;

   int checks = 0;
   int errors = 0;

   logic [TOT-1:0] capPress, capRelease, capOther;
   int strobeCount, strobeCycle;

   typedef struct {
      int          nbits;
      logic [23:0] frame;
      logic [23:0] expButtons;
      logic [1:0]  expPresent;
      logic [23:0] expPress;
      logic [23:0] expRelease;
   } vec_t;

   vec_t vecs[8];

   // Free-running system clock
   always #5 clk = ~clk;

   gamepad_pmod_multi #(
      .NUM_PADS(NP),
      .TIMEOUT_CYCLES(TMO),
      .REPEAT_DELAY(3),
      .REPEAT_PERIOD(2)
   ) dut (
      .clk_i(clk),
      .reset_i(reset),
      .pmod_data_i(pmodData),
      .pmod_clk_i(pmodClk),
      .pmod_latch_i(pmodLatch),
      .buttons_o(buttons),
      .press_o(press),
      .release_o(rel),
      .is_present_o(isPresent),
      .frame_strobe_o(frameStrobe),
      .timeout_o(timeoutSig)
   );

   // Compare one value and report a mismatch on a single line
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   // Shift nbits of value MSB first over the Pmod serial lines, two clocks per phase
   task automatic applyStimulus(input int nbits, input logic [23:0] value);
      for (int i = nbits - 1; i >= 0; i--) begin
         pmodData = value[i];
         pmodClk  = 1'b0;
         repeat (2) @(negedge clk);
         pmodClk = 1'b1;
         repeat (2) @(negedge clk);
      end
      pmodClk = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Pulse the latch and record what happens over the next 8 system clocks
   task automatic latchCapture(input bit alsoClk);
      pmodLatch = 1'b1;
      if (alsoClk) pmodClk = 1'b1;
      capPress = '0;
      capRelease = '0;
      capOther = '0;
      strobeCount = 0;
      strobeCycle = 0;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 2) begin
            pmodLatch = 1'b0;
            pmodClk = 1'b0;
         end
         if (frameStrobe) begin
            strobeCount++;
            strobeCycle = n;
         end
         if (n == 4) begin
            capPress = press;
            capRelease = rel;
         end else begin
            capOther |= press | rel;
         end
      end
   endtask

   // Table of frames applied in order, each expectation relative to the previous frame
   initial begin
      vecs[0] = '{24, 24'hFFF080, 24'h000080, 2'b01, 24'h000080, 24'h000000};
      vecs[1] = '{24, 24'hFFF080, 24'h000080, 2'b01, 24'h000000, 24'h000000};
      vecs[2] = '{24, 24'hFFF000, 24'h000000, 2'b01, 24'h000000, 24'h000080};
      vecs[3] = '{12, 24'h000800, 24'h000800, 2'b01, 24'h000800, 24'h000000};
      vecs[4] = '{24, 24'h001800, 24'h001800, 2'b11, 24'h001000, 24'h000000};
      vecs[5] = '{24, 24'hFFFFFF, 24'h000000, 2'b00, 24'h000000, 24'h001800};
      vecs[6] = '{24, 24'hABC123, 24'hABC123, 2'b11, 24'hABC123, 24'h000000};
      vecs[7] = '{24, 24'hCBA123, 24'hCBA123, 2'b11, 24'h402000, 24'h204000};
   end

   // Main sequence
   initial begin
      logic [9:0] expRepeat;
      logic [TOT-1:0] seen;
      int firstTo;
      logic [NP-1:0] presentAtTo;
      logic [TOT-1:0] relAfterTo;
      logic strobeAfterTo;

      reset = 1'b1;
      pmodData = 1'b0;
      pmodClk = 1'b0;
      pmodLatch = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_buttons", 32'(buttons), 32'h0);
      checkOutput("reset_press", 32'(press), 32'h0);
      checkOutput("reset_release", 32'(rel), 32'h0);
      checkOutput("reset_present", 32'(isPresent), 32'h0);
      checkOutput("reset_strobe", 32'(frameStrobe), 32'h0);
      checkOutput("reset_timeout", 32'(timeoutSig), 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].nbits, vecs[v].frame);
         latchCapture(1'b0);
         checkOutput($sformatf("v%0d_buttons", v), 32'(buttons), 32'(vecs[v].expButtons));
         checkOutput($sformatf("v%0d_present", v), 32'(isPresent), 32'(vecs[v].expPresent));
         checkOutput($sformatf("v%0d_press", v), 32'(capPress), 32'(vecs[v].expPress));
         checkOutput($sformatf("v%0d_release", v), 32'(capRelease), 32'(vecs[v].expRelease));
         checkOutput($sformatf("v%0d_strobe", v), 32'(strobeCycle * 10 + strobeCount), 32'd41);
         checkOutput($sformatf("v%0d_stray", v), 32'(capOther), 32'h0);
      end

      // Clock edge colliding with the latch edge: the 12th bit is lost and pad 0 keeps a leading 1
      applyStimulus(11, 24'h000000);
      pmodData = 1'b0;
      latchCapture(1'b1);
      checkOutput("collide_buttons", 32'(buttons), 32'h000800);
      checkOutput("collide_present", 32'(isPresent), 32'h1);
      applyStimulus(12, 24'h000001);
      latchCapture(1'b0);
      checkOutput("collide_next_buttons", 32'(buttons), 32'h000001);
      checkOutput("collide_next_present", 32'(isPresent), 32'h1);

      // Hold button a over 10 frames
`ifdef GAMEPAD_PMOD_REPEAT_EN
      expRepeat = 10'b10_1010_1001;
`else
      expRepeat = 10'b00_0000_0001;
`endif
      for (int f = 0; f < 10; f++) begin
         applyStimulus(12, 24'h000008);
         latchCapture(1'b0);
         checkOutput($sformatf("repeat_f%0d_press3", f + 1), 32'(capPress[3]), 32'(expRepeat[f]));
      end

      // Watchdog: hold up, then stop latching
      applyStimulus(12, 24'h000080);
      latchCapture(1'b0);
      checkOutput("wd_pre_timeout", 32'(timeoutSig), 32'h0);
      firstTo = 0;
      presentAtTo = '1;
      relAfterTo = '0;
      strobeAfterTo = 1'b0;
      for (int n = 9; n <= TMO + 10; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (timeoutSig && firstTo == 0) firstTo = n;
         if (n == TMO + 3) presentAtTo = isPresent;
         if (n == TMO + 4) begin
            relAfterTo = rel;
            strobeAfterTo = frameStrobe;
         end
      end
      checkOutput("wd_fire_cycle", 32'(firstTo), 32'(TMO + 3));
      checkOutput("wd_present", 32'(presentAtTo), 32'h0);
      checkOutput("wd_release", 32'(relAfterTo), 32'h000080);
      checkOutput("wd_strobe", 32'(strobeAfterTo), 32'h1);
      applyStimulus(12, 24'h000080);
      latchCapture(1'b0);
      checkOutput("wd_cleared", 32'(timeoutSig), 32'h0);
      checkOutput("wd_recover_press", 32'(capPress), 32'h000080);

      // Reset in the middle of a frame
      applyStimulus(10, 24'h0003FF);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seen = '0;
      strobeCount = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         seen |= press | rel;
         if (frameStrobe) strobeCount++;
      end
      checkOutput("midreset_pulses", 32'(seen), 32'h0);
      checkOutput("midreset_strobe", 32'(strobeCount), 32'h0);
      checkOutput("midreset_buttons", 32'(buttons), 32'h0);
      applyStimulus(12, 24'h000040);
      latchCapture(1'b0);
      checkOutput("midreset_frame_buttons", 32'(buttons), 32'h000040);
      checkOutput("midreset_frame_press", 32'(capPress), 32'h000040);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case the sequence never completes
   initial begin
      #1000000;
      $display("[TB] FAIL global_time_limit actual=expired required=done");
      $fatal(1, "[TB] time limit");
   end

endmodule
